// File: rtl/pipe_add32.sv
// Two-stage pipelined adder/subtractor with valid/ready handshake.
// Low half resolves in stage 1, high half in stage 2 using the registered low carry.

module pipe_add32_cla #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  logic [N-1:0] g, p;
  logic [N:0]   c;

  // Each carry is the flat lookahead sum of generate terms, not a ripple.
  always_comb begin
    logic t, pr;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = ci;
    for (int k = 0; k < N; k++) begin
      t  = g[k];
      pr = p[k];
      for (int j = k - 1; j >= 0; j--) begin
        t  = t | (pr & g[j]);
        pr = pr & p[j];
      end
      c[k+1] = t | (pr & ci);
    end
  end

  assign s  = p ^ c[N-1:0];
  assign co = c[N];
endmodule

module pipe_add32_chain #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  localparam int NS = (N + 3) / 4;

  logic [NS:0] c;
  assign c[0] = ci;

  // Slices of 4; the last one takes whatever width remains.
  for (genvar i = 0; i < NS; i++) begin : g_slice
    localparam int SW = (i == NS - 1) ? (N - 4 * i) : 4;
    pipe_add32_cla #(.N(SW)) u_cla (
      .a  (a[4*i +: SW]),
      .b  (b[4*i +: SW]),
      .ci (c[i]),
      .s  (s[4*i +: SW]),
      .co (c[i+1])
    );
  end

  assign co = c[NS];
endmodule

module pipe_add32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int H = WIDTH / 2;

  typedef struct packed {
    logic [H-1:0] lo_sum;
    logic         lo_c;
    logic [H-1:0] a_hi;
    logic [H-1:0] b_hi;
  } s1_t;

  logic             s1_valid, s2_valid;
  logic             adv1, adv2;
  s1_t              s1;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [H-1:0]     lo_s, hi_s;
  logic             lo_c, hi_c;
  logic             msb_cin;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  // Subtraction is a + ~b + 1, so cin is ignored when sub is set.
  assign b_eff = sub ? ~b : b;
  assign c0    = sub | cin;

  pipe_add32_chain #(.N(H)) u_lo (
    .a  (a[H-1:0]),
    .b  (b_eff[H-1:0]),
    .ci (c0),
    .s  (lo_s),
    .co (lo_c)
  );

  pipe_add32_chain #(.N(H)) u_hi (
    .a  (s1.a_hi),
    .b  (s1.b_hi),
    .ci (s1.lo_c),
    .s  (hi_s),
    .co (hi_c)
  );

  assign msb_cin = s1.a_hi[H-1] ^ s1.b_hi[H-1] ^ hi_s[H-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1.lo_sum <= lo_s;
        s1.lo_c   <= lo_c;
        s1.a_hi   <= a[WIDTH-1:H];
        s1.b_hi   <= b_eff[WIDTH-1:H];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= {hi_s, s1.lo_sum};
        cout <= hi_c;
        ovf  <= msb_cin ^ hi_c;
      end
    end
  end
endmodule

// File: tb/tb_pipe_add32.sv
// Directed and random checks of pipe_add32: latency, flags, backpressure, async reset.

module tb_pipe_add32;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0;
  logic        cin = 1'b0, sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout, ovf;

  int nchk = 0, nerr = 0;
  int nout = 0, nacc = 0;
  bit mon_en = 1'b0;
  bit drv_busy = 1'b0;
  bit rnd_on = 1'b0;
  bit held = 1'b0;
  logic [33:0] hv;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_add32 #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, cout, sum}
  function automatic logic [33:0] model(input logic [31:0] va, vb, input logic vc, vs);
    logic [31:0] be;
    logic [32:0] r;
    logic        o;
    be = vs ? ~vb : vb;
    r  = {1'b0, va} + {1'b0, be} + {32'd0, (vs ? 1'b1 : vc)};
    o  = (va[31] == be[31]) && (r[31] != va[31]);
    return {o, r[32], r[31:0]};
  endfunction

  // Transfers are decided by the handshake levels seen at the negedge before the edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held && out_valid) chk("hold", {ovf, cout, sum}, hv);
      held = out_valid && !out_ready;
      hv   = {ovf, cout, sum};
      if (mon_en) begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
          else chk("stream", {ovf, cout, sum}, exp_q.pop_front());
          nout++;
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model(a, b, cin, sub));
          nacc++;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] va, vb, input logic vc, vs);
    int  n = 0;
    bit  acc;
    a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      if (++n > 200) begin chk("send_timeout", 0, 1); break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic direct(input string tag, input logic [31:0] va, vb, input logic vc, vs,
                        input logic [31:0] es, input logic ec, eo);
    a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
    @(negedge clk); chk({tag, "_rdy"}, in_ready, 1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); chk({tag, "_lat1"}, out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    @(posedge clk); #1;
  endtask

  initial begin
    int base, n;
    #2;
    chk("rst_vld", out_valid, 0);
    chk("rst_rdy", in_ready, 1);
    chk("rst_data", {ovf, cout, sum}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    direct("xhalf",  32'h0000FFFF, 32'h00000001, 0, 0, 32'h00010000, 0, 0);
    direct("povf",   32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1);
    direct("wrap",   32'hFFFFFFFF, 32'h00000001, 1, 0, 32'h00000001, 1, 0);
    direct("allone", 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0);
    direct("sub_neg", 32'h00000005, 32'h00000007, 1, 1, 32'hFFFFFFFE, 0, 0);
    direct("sub_ovf", 32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1, 1);
    direct("sub_zero", 32'h00000000, 32'h00000000, 0, 1, 32'h00000000, 1, 0);

    // Backpressure: two acceptances fill the pipe, then in_ready must drop.
    mon_en = 1'b1; base = nacc; out_ready = 1'b0;
    fork
      begin
        drv_busy = 1'b1;
        send(32'd1, 32'd2, 0, 0);
        send(32'd10, 32'd20, 0, 0);
        send(32'd100, 32'd1, 0, 1);
        send(32'hFFFFFFFF, 32'd1, 0, 0);
        drv_busy = 1'b0;
      end
    join_none
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bp_rdy", in_ready, 0);
    chk("bp_vld", out_valid, 1);
    chk("bp_sum", sum, 32'd3);
    chk("bp_acc", nacc - base, 2);
    @(posedge clk); #1; out_ready = 1'b1;
    n = 0;
    while ((drv_busy || exp_q.size() != 0) && n < 100) begin @(posedge clk); n++; end
    #1;
    chk("bp_drain", exp_q.size(), 0);
    chk("bp_count", nout, 4);

    // Async reset with both stages full.
    mon_en = 1'b0; out_ready = 1'b0;
    send(32'h11, 32'h22, 0, 0);
    send(32'h33, 32'h44, 0, 0);
    chk("pre_rst_vld", out_valid, 1);
    chk("pre_rst_rdy", in_ready, 0);
    #2; rst_n = 1'b0;
    #1;
    chk("arst_vld", out_valid, 0);
    chk("arst_rdy", in_ready, 1);
    chk("arst_data", {ovf, cout, sum}, 0);
    #3; rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) begin @(negedge clk); chk("post_rst_idle", out_valid, 0); end
    @(posedge clk); #1;
    direct("post_rst", 32'h12345678, 32'h11111111, 0, 0, 32'h23456789, 0, 0);

    // Random stream with gaps and random backpressure.
    mon_en = 1'b1; base = nout; rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          logic [31:0] ra, rb;
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          ra = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
          rb = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
          send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin @(posedge clk); #1; out_ready = 1'($urandom_range(0, 1)); end
      end
    join
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    #1;
    chk("rnd_drain", exp_q.size(), 0);
    chk("rnd_count", nout - base, 10000);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/pipe_add32.md
PIPE_ADD32 -- requirements
Module: pipe_add32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; legal values are even numbers from 8 to 64.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  upstream operands valid.
REQ-005 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port cin  input  1  carry-in, used only when sub=0.
REQ-009 SHALL have port sub  input  1  1 = compute a - b, 0 = compute a + b + cin.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port sum  output  WIDTH  result bits.
REQ-013 SHALL have port cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-014 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL be a two-stage pipeline: stage 1 adds the low WIDTH/2 bits, stage 2 adds the high WIDTH/2 bits using the stage-1 carry.
REQ-016 SHALL form the effective operand as b_eff = sub ? ~b : b and the effective carry as c0 = sub ? 1 : cin, both captured at acceptance.
REQ-017 Stage 1 SHALL register: low sum, low carry-out, high halves of a and b_eff, and s1_valid.
REQ-018 Stage 2 SHALL register: full sum, cout, ovf, and s2_valid; s2_valid drives out_valid.
REQ-019 Each half-adder SHALL be a chain of 4-bit carry-lookahead slices with a rippled carry; a WIDTH/2 value that is not a multiple of 4 uses one narrower final slice.
REQ-020 ovf SHALL equal carry-into-MSB XOR cout of the stage-2 addition.
REQ-021 Acceptance: a transfer occurs when in_valid and in_ready are both 1 at a rising edge.
REQ-022 Output transfer: a transfer occurs when out_valid and out_ready are both 1 at a rising edge.
REQ-023 Advance signals: adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1 (combinational from out_ready; no combinational path from in_valid to in_ready).
REQ-024 Latency SHALL be exactly 2 cycles from acceptance to out_valid when out_ready is held at 1; throughput SHALL be one result per cycle.
REQ-025 When adv2=0, stage 2 registers SHALL hold, and sum/cout/ovf SHALL stay stable while out_valid=1.
REQ-026 When adv1=0, stage 1 registers SHALL hold and in_ready SHALL be 0.
REQ-027 When a stage advances without new input, its valid SHALL clear and its data registers MAY hold stale values.
REQ-028 Simultaneous output transfer and acceptance in the same cycle SHALL be lossless, with no bubble inserted.
REQ-029 Wrap-around SHALL be modulo 2^WIDTH; cout carries the lost bit.

Reset
REQ-030 Asserting rst_n low SHALL immediately clear s1_valid and s2_valid, so out_valid=0 and in_ready=1, regardless of clock.
REQ-031 Data registers SHALL reset to 0, so sum=0, cout=0, and ovf=0 during reset.
REQ-032 Reset mid-operation SHALL discard in-flight results; after rst_n deasserts, no out_valid is seen until 2 edges after a new acceptance.

Verification
REQ-033 Directed: a=0x0000FFFF, b=0x00000001, cin=0, sub=0 -> sum=0x00010000, cout=0, ovf=0, after 2 cycles (cross-half carry).
REQ-034 Directed: a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, ovf=1, cout=0; then a=0xFFFFFFFF, b=0x00000001, cin=1 -> sum=0x00000001, cout=1, ovf=0.
REQ-035 Directed: a=0x00000005, b=0x00000007, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0, ovf=0 (cin ignored); a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, ovf=1, cout=1.
REQ-036 Directed: stream 4 back-to-back operands with out_ready=0 -> in_ready drops after 2 acceptances, the held sum is stable; releasing out_ready yields all 4 results in order with no loss or duplication.
REQ-037 Directed: rst_n pulsed low while both stages are valid (asynchronous to clk) -> out_valid falls without an edge, and the next result appears only for operands accepted after release.
REQ-038 Random: 10k random a, b, cin, sub values with random in_valid/out_ready are compared against a reference model modulo 2^32; zero mismatches, in order.
